// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter. One-cycle byte writes are queued
//            in a 2^FIFO_AW-entry circular FIFO and shifted out LSB first.
// Ports    : clk, rst        - system clock, synchronous active-high reset
//            tx_en, tx_data  - push strobe and byte to queue
//            ovr_clr         - clears the sticky overrun flag
//            txd             - serial line (idles high, registered)
//            tx_busy         - frame in progress (start through stop)
//            tx_full/empty   - registered FIFO status
//            tx_count        - FIFO occupancy 0..2^FIFO_AW
//            tx_overrun      - sticky, set when a push is dropped
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic [7:0]         tx_data,
    input  logic               ovr_clr,
    output logic               txd,
    output logic               tx_busy,
    output logic               tx_full,
    output logic               tx_empty,
    output logic [FIFO_AW:0]   tx_count,
    output logic               tx_overrun
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH  = 2 ** FIFO_AW;

    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  c_DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overrun;

    logic               w_push;
    logic               w_pop;
    logic [FIFO_AW:0]   w_count_next;
    logic [7:0]         w_head;

    // Full is the registered pre-edge value, so a push against a full FIFO
    // is dropped even if the FSM pops in the same cycle.
    assign w_push = tx_en && !r_full;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (FIFO_AW+1)'(1);
            2'b01:   w_count_next = r_count - (FIFO_AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            r_empty <= (w_count_next == '0);
            // A dropped push wins over a same-cycle clear.
            if (tx_en && r_full) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              w_baud_last;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_bit_next   = 3'd0;
                    w_baud_next  = '0;
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_state_next = c_DATA;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            c_DATA: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = c_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            default: begin // c_STOP
                if (w_baud_last) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_bit_next   = 3'd0;
                        w_state_next = c_START;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
        endcase

        // Line level is computed from the next state so the pin flop
        // changes on the same edge as the state.
        case (w_state_next)
            c_START: w_txd_next = 1'b0;
            c_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
        end
    end

    assign txd        = r_txd;
    assign tx_busy    = (r_state != c_IDLE);
    assign tx_full    = r_full;
    assign tx_empty   = r_empty;
    assign tx_count   = r_count;
    assign tx_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo. One instance
//            with a 16-entry FIFO, one with a 4-entry FIFO, both at 4 clocks
//            per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       ovr_clr;
    logic [7:0] tx_data;
    logic       en1;
    logic       en2;

    logic       txd1, busy1, full1, empty1, ovr1;
    logic [4:0] count1;
    logic       txd2, busy2, full2, empty2, ovr2;
    logic [2:0] count2;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (en1),
        .tx_data    (tx_data),
        .ovr_clr    (ovr_clr),
        .txd        (txd1),
        .tx_busy    (busy1),
        .tx_full    (full1),
        .tx_empty   (empty1),
        .tx_count   (count1),
        .tx_overrun (ovr1)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) u_dut_small (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (en2),
        .tx_data    (tx_data),
        .ovr_clr    (ovr_clr),
        .txd        (txd2),
        .tx_busy    (busy2),
        .tx_full    (full2),
        .tx_empty   (empty2),
        .tx_count   (count2),
        .tx_overrun (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot idx (0 start, 1..8 data, 9 stop).
    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    logic [7:0] b2b [3];
    logic [7:0] ov  [5];

    initial begin
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
        ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;

        rst = 1'b1; ovr_clr = 1'b0; tx_data = 8'h00; en1 = 1'b0; en2 = 1'b0;

        // ---------------- reset / idle ----------------
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_txd",   txd1,   1);
        chk("rst_busy",  busy1,  0);
        chk("rst_empty", empty1, 1);
        chk("rst_full",  full1,  0);
        chk("rst_count", count1, 0);
        chk("rst_ovr",   ovr1,   0);
        chk("rst_txd2",  txd2,   1);
        chk("rst_empty2",empty2, 1);
        for (int i = 0; i < 20; i++) begin
            chk("idle_line", {txd1, busy1, empty1, count1}, {1'b1, 1'b0, 1'b1, 5'd0});
            step();
        end

        // ---------------- single byte 0xA5 ----------------
        tx_data = 8'hA5; en1 = 1'b1;
        step();                                   // edge E
        en1 = 1'b0;
        chk("push_count", count1, 1);
        chk("push_empty", empty1, 0);
        chk("push_busy",  busy1,  0);
        chk("push_txd",   txd1,   1);
        step();                                   // edge E+1
        chk("pop_count", count1, 0);
        for (int k = 0; k < 10 * CPB; k++) begin
            chk("a5_txd",  txd1,  fbit(8'hA5, k / CPB));
            chk("a5_busy", busy1, 1);
            step();
        end
        chk("a5_end_busy", busy1, 0);
        chk("a5_end_txd",  txd1,  1);

        // ---------------- back-to-back 0x00, 0xFF, 0x55 ----------------
        tx_data = 8'h00; en1 = 1'b1;
        step();
        chk("b2b_count1", count1, 1);
        tx_data = 8'hFF;
        step();                                   // first pop happens here
        for (int k = 0; k < 30 * CPB; k++) begin
            if (k == 0) begin
                chk("b2b_count2", count1, 1);
                tx_data = 8'h55;
            end
            if (k == 1) begin
                chk("b2b_count3", count1, 2);
            end
            chk("b2b_txd",  txd1,  fbit(b2b[k / (10 * CPB)], (k % (10 * CPB)) / CPB));
            chk("b2b_busy", busy1, 1);
            step();
            if (k == 0) en1 = 1'b0;
        end
        chk("b2b_end_busy",  busy1,  0);
        chk("b2b_end_empty", empty1, 1);
        chk("b2b_end_count", count1, 0);

        // ---------------- full / overrun on the 4-entry FIFO ----------------
        en2 = 1'b1;
        tx_data = 8'h11; step();                  // edge 1
        chk("ov_c1", count2, 1);
        tx_data = 8'h22; step();                  // edge 2: first pop
        chk("ov_c2", count2, 1);
        chk("ov_busy", busy2, 1);
        tx_data = 8'h33; step();                  // edge 3
        tx_data = 8'h44; step();                  // edge 4
        chk("ov_c4", count2, 3);
        chk("ov_full4", full2, 0);
        tx_data = 8'h55; step();                  // edge 5
        chk("ov_full5", full2, 1);
        chk("ov_c5", count2, 4);
        chk("ov_ovr5", ovr2, 0);
        tx_data = 8'h66; step();                  // edge 6: dropped
        chk("ov_ovr6", ovr2, 1);
        chk("ov_c6", count2, 4);
        // Same-cycle drop and clear: set wins.
        tx_data = 8'h77; ovr_clr = 1'b1; step();  // edge 7
        chk("ov_prio", ovr2, 1);
        chk("ov_c7", count2, 4);
        en2 = 1'b0; step();                       // edge 8: clear
        ovr_clr = 1'b0;
        chk("ov_clr", ovr2, 0);
        for (int k = 6; k < 50 * CPB; k++) begin
            chk("ov_txd", txd2, fbit(ov[k / (10 * CPB)], (k % (10 * CPB)) / CPB));
            step();
        end
        chk("ov_end_busy",  busy2,  0);
        chk("ov_end_empty", empty2, 1);
        chk("ov_end_full",  full2,  0);

        // ---------------- reset mid-frame ----------------
        tx_data = 8'h3C; en1 = 1'b1; step();      // push 0x3C
        tx_data = 8'h99; step();                  // pop 0x3C, push 0x99
        en1 = 1'b0;
        // Sample k=0 is the first start-bit cycle; data bit 3 is slot 4.
        for (int k = 0; k < 4 * CPB + 1; k++) begin
            chk("mf_txd", txd1, fbit(8'h3C, k / CPB));
            step();
        end
        chk("mf_pre_count", count1, 1);
        rst = 1'b1; step();
        chk("mf_rst_txd",   txd1,   1);
        chk("mf_rst_count", count1, 0);
        chk("mf_rst_busy",  busy1,  0);
        chk("mf_rst_empty", empty1, 1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("mf_idle", {txd1, busy1}, {1'b1, 1'b0});
            step();
        end
        tx_data = 8'h81; en1 = 1'b1; step();
        en1 = 1'b0; step();
        for (int k = 0; k < 10 * CPB; k++) begin
            chk("mf_81_txd",  txd1,  fbit(8'h81, k / CPB));
            chk("mf_81_busy", busy1, 1);
            step();
        end
        chk("mf_81_end", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
